linear_result_collector: RTL and testbench
==========================================

# linear_result_collector

Gathers the scalar float results emitted one per `done` strobe by the 32-input linear unit into a full 32-element vector, so one RNN layer's hidden state can be handed to the next layer's vector input. Ping-pong double buffer: one bank fills while the other is held for the consumer. The upstream adder has no output backpressure, so the block never stalls its input. It drops and flags results only when both banks are occupied.

## Interface
- `DEPTH`, 32, elements per vector (power of two, ≥2)
- `WIDTH`, 32, element width (IEEE-754 single)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `clear`  in  1  synchronous flush (see Operation)
- `in_done`  in  1  one-cycle strobe: `in_result` valid (driven by linear unit `done`)
- `in_result`  in  WIDTH  scalar result
- `in_ready`  out  1  a bank is available for filling (advisory to issuing controller)
- `fill_count`  out  $clog2(DEPTH)  elements already written into current fill bank
- `vec_valid`  out  1  output vector held
- `vec_ready`  in  1  consumer accepts vector
- `vec_data`  out  WIDTH × DEPTH (unpacked `[DEPTH-1:0]`)  element k = k-th captured result of that bank
- `overflow`  out  1  sticky: a result was dropped

## Operation
- State: `bank[2][DEPTH]`, `wr_bank`, `wr_idx`, `rd_bank`, `full[1:0]`, `overflow`.
- Capture: `in_done && !full[wr_bank]`, with values sampled before the edge:
  - `bank[wr_bank][wr_idx] <= cap(in_result)`, then `wr_idx++`.
  - If `wr_idx==DEPTH-1`: set `full[wr_bank]`, toggle `wr_bank`, `wr_idx <= 0`.
- Drop: `in_done && full[wr_bank]`, meaning both banks are occupied.
  - Result discarded and `overflow <= 1`.
  - A release in the same cycle does not rescue it; the release is visible next cycle.
- Release: `vec_valid && vec_ready` clears `full[rd_bank]` and toggles `rd_bank`.
- Simultaneous capture-complete and release: both apply independently. They always target different banks.
- `vec_valid = full[rd_bank]`; `vec_data = bank[rd_bank]` (registered storage, mux only).
- `in_ready = !full[wr_bank]`.
- `fill_count = wr_idx`.
- `clear`: `full<=0`, `wr_idx<=0`, `wr_bank<=0`, `rd_bank<=0`, `overflow<=0`; bank contents retained. `clear` has priority over a same-cycle capture or release; such a capture is discarded and not flagged.
- Reset (async): all state including bank storage goes to 0. After reset: `vec_valid=0`, `vec_data` all 0, `in_ready=1`, `fill_count=0`, `overflow=0`. Assertion mid-fill abandons the partial vector.
- `vec_data` is stable while `vec_valid && !vec_ready`.

## Timing
- Capture takes 1 cycle. If the DEPTH-th strobe is sampled at edge N, `vec_valid` is high from edge N (visible in cycle N+1).
- Release at edge M: `vec_valid` falls after M, or stays high with the other bank's data if that bank is already full.
- Back-to-back strobes every cycle are sustained indefinitely provided the consumer releases each vector within DEPTH cycles.
- No combinational path from `in_*` to `vec_*`. `vec_ready` affects only registered state.

## Configuration
- `LINEAR_COLLECT_RELU_EN` defined: `cap(x) = x[WIDTH-1] ? 0 : x`. This gives a ReLU on capture; -0.0 (`0x80000000`) and negative-signed NaNs store as `0x00000000`.
- Not defined: `cap(x) = x`, stored bit-exact.

## Test plan
- Reset then 32 strobes, one per cycle, with `in_result = 0x3F800000 + k`, `vec_ready=0`.
  - Response: `vec_valid` rises the cycle after the 32nd strobe; `vec_data[k]` matches; `fill_count=0`; `in_ready=1`.
- Continue with 32 more strobes, then a 65th, holding `vec_ready=0`.
  - Response: second bank fills and `in_ready=0`.
  - 65th strobe is dropped and `overflow=1`.
  - Assert `vec_ready` for 1 cycle: `vec_valid` stays 1 and `vec_data` switches to the second vector.
- Release coinciding with a strobe while both banks are full.
  - Response: the strobe is dropped, `overflow=1`; the next strobe is captured at index 0.
- With `LINEAR_COLLECT_RELU_EN`, feed `0xBF800000`, `0x80000000`, `0x40000000`.
  - Response: stored `0`, `0`, `0x40000000`. Without the macro, stored unchanged.
- Assert `rst` after 10 strobes.
  - Response: all outputs at reset values immediately; the next 32 strobes form a fresh vector starting at element 0.
- `clear` after 5 strobes, in the same cycle as a strobe.
  - Response: `fill_count=0`, `overflow=0`, no `vec_valid`; the next 32 strobes produce one vector.

Source files
------------

// File: rtl/linear_result_collector.sv
// Ping-pong collector: assembles DEPTH scalar results into a vector while the other bank is held for the consumer.
// Optional ReLU on capture when LINEAR_COLLECT_RELU_EN is defined.
module linear_result_collector #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     in_done,
   input  logic [WIDTH-1:0]         in_result,
   output logic                     in_ready,
   output logic [$clog2(DEPTH)-1:0] fill_count,
   output logic                     vec_valid,
   input  logic                     vec_ready,
   output logic [WIDTH-1:0]         vec_data [DEPTH-1:0],
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [2][DEPTH];
   logic             wr_bank;
   logic             rd_bank;
   logic [AW-1:0]    wr_idx;
   logic [1:0]       full;
   logic [WIDTH-1:0] cap_value;

`ifdef LINEAR_COLLECT_RELU_EN
   // Sign bit set covers negatives, -0.0 and negative-signed NaNs alike.
   assign cap_value = in_result[WIDTH-1] ? '0 : in_result;
`else
   assign cap_value = in_result;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++)
            for (int k = 0; k < DEPTH; k++)
               mem[b][k] <= '0;
         wr_bank  <= 1'b0;
         rd_bank  <= 1'b0;
         wr_idx   <= '0;
         full     <= 2'b00;
         overflow <= 1'b0;
      end else if (clear) begin
         wr_bank  <= 1'b0;
         rd_bank  <= 1'b0;
         wr_idx   <= '0;
         full     <= 2'b00;
         overflow <= 1'b0;
      end else begin
         if (in_done) begin
            if (!full[wr_bank]) begin
               mem[wr_bank][wr_idx] <= cap_value;
               if (wr_idx == AW'(DEPTH - 1)) begin
                  full[wr_bank] <= 1'b1;
                  wr_bank       <= ~wr_bank;
                  wr_idx        <= '0;
               end else begin
                  wr_idx <= wr_idx + 1'b1;
               end
            end else begin
               overflow <= 1'b1;
            end
         end
         // Release always targets the other bank from a completing capture.
         if (full[rd_bank] && vec_ready) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= ~rd_bank;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < DEPTH; k++)
         vec_data[k] = mem[rd_bank][k];
   end

   assign vec_valid  = full[rd_bank];
   assign in_ready   = !full[wr_bank];
   assign fill_count = wr_idx;

endmodule

// File: tb/tb_linear_result_collector.sv
// Randomized and directed bench for linear_result_collector against a queue-based vector model.
module tb_linear_result_collector;

   localparam int DEPTH = 32;
   localparam int WIDTH = 32;

   typedef logic [WIDTH-1:0] vec_t [DEPTH];

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             clear = 1'b0;
   logic             in_done = 1'b0;
   logic [WIDTH-1:0] in_result = '0;
   logic             in_ready;
   logic [4:0]       fill_count;
   logic             vec_valid;
   logic             vec_ready = 1'b0;
   logic [WIDTH-1:0] vec_data [DEPTH-1:0];
   logic             overflow;

   int tests = 0;
   int fails = 0;

   vec_t comp[$];
   vec_t pvec;
   int   pcnt = 0;
   bit   m_ovf = 1'b0;

   linear_result_collector #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_done(in_done), .in_result(in_result),
      .in_ready(in_ready), .fill_count(fill_count), .vec_valid(vec_valid),
      .vec_ready(vec_ready), .vec_data(vec_data), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] model_cap(input logic [WIDTH-1:0] x);
`ifdef LINEAR_COLLECT_RELU_EN
      if (x[WIDTH-1]) return '0;
`endif
      return x;
   endfunction

   task automatic model_reset();
      comp.delete();
      pcnt  = 0;
      m_ovf = 1'b0;
   endtask

   task automatic check_outputs();
      int n;
      n = comp.size();
      check("vec_valid", 64'(vec_valid), 64'(n > 0));
      check("in_ready", 64'(in_ready), 64'(n < 2));
      check("fill_count", 64'(fill_count), 64'(pcnt));
      check("overflow", 64'(overflow), 64'(m_ovf));
      if (n > 0)
         for (int k = 0; k < DEPTH; k++)
            check($sformatf("vec_data[%0d]", k), 64'(vec_data[k]), 64'(comp[0][k]));
   endtask

   // One clock cycle: inputs applied before the edge, model advanced, outputs checked after it.
   task automatic step(input bit d, input logic [WIDTH-1:0] v, input bit rdy, input bit clr);
      bit rel;
      in_done = d; in_result = v; vec_ready = rdy; clear = clr;
      @(posedge clk);
      if (clr) begin
         model_reset();
      end else begin
         rel = (comp.size() > 0) && rdy;
         if (d) begin
            if (comp.size() < 2) begin
               pvec[pcnt] = model_cap(v);
               pcnt++;
               if (pcnt == DEPTH) begin
                  comp.push_back(pvec);
                  pcnt = 0;
               end
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (rel) void'(comp.pop_front());
      end
      #1;
      in_done = 1'b0; vec_ready = 1'b0; clear = 1'b0;
      check_outputs();
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_valid"}, 64'(vec_valid), 64'(0));
      check({tag, "_ready"}, 64'(in_ready), 64'(1));
      check({tag, "_fill"}, 64'(fill_count), 64'(0));
      check({tag, "_ovf"}, 64'(overflow), 64'(0));
      for (int k = 0; k < DEPTH; k++)
         check($sformatf("%s_data[%0d]", tag, k), 64'(vec_data[k]), 64'(0));
   endtask

   initial begin
      logic [WIDTH-1:0] relu_in [3];
      relu_in[0] = 32'hBF80_0000;
      relu_in[1] = 32'h8000_0000;
      relu_in[2] = 32'h4000_0000;

      #1;
      check_reset_state("reset");
      @(negedge clk);
      rst = 1'b0;

      // First vector
      for (int k = 0; k < DEPTH; k++) step(1, 32'h3F80_0000 + k, 0, 0);
      // Second vector then a dropped 65th strobe
      for (int k = 0; k < DEPTH; k++) step(1, 32'h4100_0000 + k, 0, 0);
      step(1, 32'hDEAD_BEEF, 0, 0);
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);

      // Refill so both banks are full, then release coinciding with a strobe
      for (int k = 0; k < DEPTH; k++) step(1, 32'h4200_0000 + k, 0, 0);
      step(1, 32'h1234_5678, 1, 0);
      step(1, 32'h0BAD_F00D, 0, 0);
      check("idx0_after_drop", 64'(fill_count), 64'(1));
      for (int k = 0; k < 3; k++) step(0, 0, 1, 0);
      for (int k = 1; k < DEPTH; k++) step(1, 32'h4300_0000 + k, 0, 0);
      step(0, 0, 1, 0);

      // Capture transform on sign-bit values
      for (int k = 0; k < DEPTH; k++) step(1, (k < 3) ? relu_in[k] : 32'h3F00_0000 + k, 0, 0);
`ifdef LINEAR_COLLECT_RELU_EN
      check("relu_neg", 64'(vec_data[0]), 64'h0);
      check("relu_negzero", 64'(vec_data[1]), 64'h0);
`else
      check("pass_neg", 64'(vec_data[0]), 64'hBF80_0000);
      check("pass_negzero", 64'(vec_data[1]), 64'h8000_0000);
`endif
      check("relu_pos", 64'(vec_data[2]), 64'h4000_0000);
      step(0, 0, 1, 0);

      // Async reset mid-fill
      for (int k = 0; k < 10; k++) step(1, 32'h5000_0000 + k, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_reset_state("midrst");
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < DEPTH; k++) step(1, 32'h6000_0000 + k, 0, 0);
      step(0, 0, 1, 0);

      // Clear coinciding with a strobe
      for (int k = 0; k < 5; k++) step(1, 32'h7000_0000 + k, 0, 0);
      step(1, 32'h7777_7777, 0, 1);
      for (int k = 0; k < DEPTH; k++) step(1, 32'h7100_0000 + k, 0, 0);
      step(0, 0, 1, 0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++)
         step(($urandom % 4) != 0, $urandom, ($urandom % 3) == 0, ($urandom % 400) == 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
